hazard_stall_unit: RTL and testbench

- Producer-side companion to the EX/MEM and MEM/WB operand-forwarding path.
- Detects the hazards that forwarding cannot resolve, and drives the pipeline-register write enables, bubbles and flushes:
  - load-use: a source register read in ID is the destination of a load in EX;
  - taken-branch redirect: instructions already fetched behind a branch taken in ID;
  - multi-cycle data-memory access: a load/store in MEM whose memory access takes more than one cycle.
- Sits in the ID-stage control logic. Outputs feed PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/hazard_stall_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / branch-flush / memory-wait stall and flush control
// Optional HAZARD_PERF_EN adds saturating 16-bit stall and flush performance counters.
module hazard_stall_unit #(
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] ifid_Rs,
   input  logic [3:0] ifid_Rt,
   input  logic       ifid_RsUsed,
   input  logic       ifid_RtUsed,
   input  logic [3:0] idex_WR,
   input  logic       idex_MemRead,
   input  logic       branch_taken,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ifid_write,
   output logic       ifid_flush,
   output logic       idex_write,
   output logic       idex_bubble,
   output logic       exmem_write,
   output logic       memwb_bubble,
   output logic       mem_timeout
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0] lu_stall_cnt,
   output logic [15:0] mem_stall_cnt,
   output logic [15:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} stateT;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

   stateT      state, nextState;
   logic [2:0] flushCnt, flushCntNext;
   logic [7:0] waitCnt, waitCntNext;
   logic       memStall, loadUse;

   assign memStall = mem_req & ~mem_ready;
   assign loadUse  = idex_MemRead & (idex_WR != 4'd0) &
                     ((ifid_RsUsed & (ifid_Rs == idex_WR)) | (ifid_RtUsed & (ifid_Rt == idex_WR)));

   // Counts consecutive stalled cycles; clears as soon as the stall releases.
   assign waitCntNext = memStall ? ((waitCnt == 8'hFF) ? 8'hFF : waitCnt + 8'd1) : 8'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         flushCnt    <= 3'd0;
         waitCnt     <= 8'd0;
         mem_timeout <= 1'b0;
      end else begin
         state    <= nextState;
         flushCnt <= flushCntNext;
         waitCnt  <= waitCntNext;
         if ((MEM_TIMEOUT != 0) && memStall && (int'(waitCntNext) == MEM_TIMEOUT))
            mem_timeout <= 1'b1;
      end
   end

   always_comb begin
      nextState    = state;
      flushCntNext = flushCnt;
      case (state)
         FLUSH: begin
            // A stall inside the flush window holds the count and keeps FLUSH.
            if (!memStall) begin
               flushCntNext = flushCnt - 3'd1;
               if (flushCnt <= 3'd1)
                  nextState = RUN;
            end
         end
         default: begin
            if (memStall)
               nextState = MEM_WAIT;
            else if (!loadUse && branch_taken && MULTI_FLUSH) begin
               nextState    = FLUSH;
               flushCntNext = FLUSH_LOAD;
            end else
               nextState = RUN;
         end
      endcase
   end

   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_bubble  = 1'b0;
      exmem_write  = 1'b1;
      memwb_bubble = 1'b0;
      if (!rst_n) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         memwb_bubble = 1'b1;
      end else if (memStall) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         memwb_bubble = 1'b1;
      end else if (state == FLUSH) begin
         ifid_flush = 1'b1;
      end else if (loadUse) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end else if (branch_taken) begin
         ifid_flush = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lu_stall_cnt  <= 16'd0;
         mem_stall_cnt <= 16'd0;
         flush_cnt     <= 16'd0;
      end else begin
         // Outside reset, idex_bubble is only ever raised by a load-use hazard.
         if (idex_bubble && lu_stall_cnt != 16'hFFFF)
            lu_stall_cnt <= lu_stall_cnt + 16'd1;
         if (memStall && mem_stall_cnt != 16'hFFFF)
            mem_stall_cnt <= mem_stall_cnt + 16'd1;
         if (ifid_flush && flush_cnt != 16'hFFFF)
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed bench for hazard_stall_unit (FLUSH_CYCLES=3, MEM_TIMEOUT=8)
module tb_hazard_stall_unit;

   // Packed as {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble}
   localparam logic [6:0] NORM = 7'b1101010;
   localparam logic [6:0] LU   = 7'b0001110;
   localparam logic [6:0] FRZ  = 7'b0000001;
   localparam logic [6:0] FL   = 7'b1111010;
   localparam logic [6:0] RST  = 7'b0010101;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] ifid_Rs, ifid_Rt, idex_WR;
   logic       ifid_RsUsed, ifid_RtUsed, idex_MemRead, branch_taken, mem_req, mem_ready;
   logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble;
   logic       mem_timeout;
`ifdef HAZARD_PERF_EN
   logic [15:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   hazard_stall_unit #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifid_Rs(ifid_Rs), .ifid_Rt(ifid_Rt), .ifid_RsUsed(ifid_RsUsed), .ifid_RtUsed(ifid_RtUsed),
      .idex_WR(idex_WR), .idex_MemRead(idex_MemRead), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
      .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
      , .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] outs();
      return {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble};
   endfunction

   task automatic chkOut(input string tag, input logic [6:0] exp);
      checks++;
      assert (outs() === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, outs(), exp);
      end
   endtask

   task automatic chkTo(input string tag, input logic exp);
      checks++;
      assert (mem_timeout === exp) else begin
         errors++;
         $error("FAIL %s mem_timeout observed=%b expected=%b", tag, mem_timeout, exp);
      end
   endtask

   // Inputs are set just after a rising edge; outputs are checked 1ns later, then advance one cycle.
   task automatic step(input string tag, input logic [6:0] exp);
      #1;
      chkOut(tag, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifid_Rs = 4'd0; ifid_Rt = 4'd0; ifid_RsUsed = 1'b0; ifid_RtUsed = 1'b0;
      idex_WR = 4'd0; idex_MemRead = 1'b0; branch_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #2;
      chkOut("reset_outputs", RST);
      chkTo("reset_timeout", 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step("idle", NORM);

      // Load-use on Rs, then the load leaves EX
      idex_MemRead = 1'b1; idex_WR = 4'd5; ifid_Rs = 4'd5; ifid_RsUsed = 1'b1;
      step("lu_rs", LU);
      idex_MemRead = 1'b0;
      step("lu_release", NORM);

      // R0 destination and unused operand never stall; a used Rt does
      idex_MemRead = 1'b1; idex_WR = 4'd0; ifid_Rs = 4'd0; ifid_RsUsed = 1'b1;
      step("lu_r0", NORM);
      idex_WR = 4'd3; ifid_Rs = 4'd1; ifid_Rt = 4'd3; ifid_RtUsed = 1'b0;
      step("lu_rt_unused", NORM);
      ifid_RtUsed = 1'b1;
      step("lu_rt_used", LU);
      idle();

      // Four-cycle memory wait, then ready
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) step($sformatf("memwait_%0d", i), FRZ);
      mem_ready = 1'b1;
      step("mem_ready", NORM);
      chkTo("memwait_no_timeout", 1'b0);
      idle();
      step("mem_idle", NORM);

      // Branch flush, lu ignored in FLUSH, stall in flush cycle 2 holds the count
      branch_taken = 1'b1;
      step("flush_1", FL);
      branch_taken = 1'b0;
      idex_MemRead = 1'b1; idex_WR = 4'd7; ifid_Rs = 4'd7; ifid_RsUsed = 1'b1;
      step("flush_2_lu_ignored", FL);
      idle();
      mem_req = 1'b1;
      step("flush_stall", FRZ);
      mem_ready = 1'b1;
      step("flush_3", FL);
      idle();
      step("flush_done", NORM);

      // Priority: lu over branch_taken
      idex_MemRead = 1'b1; idex_WR = 4'd2; ifid_Rs = 4'd2; ifid_RsUsed = 1'b1; branch_taken = 1'b1;
      step("prio_lu_branch", LU);
      idle();
      step("prio_no_flush_after", NORM);

      // Priority: memstall over lu; release cycle re-evaluates lu
      idex_MemRead = 1'b1; idex_WR = 4'd4; ifid_Rt = 4'd4; ifid_RtUsed = 1'b1; mem_req = 1'b1;
      step("prio_mem_lu", FRZ);
      mem_ready = 1'b1;
      step("release_lu", LU);
      idle();

      // Release with branch taken enters a full three-cycle flush
      mem_req = 1'b1;
      step("br_wait", FRZ);
      mem_ready = 1'b1; branch_taken = 1'b1;
      step("br_release_flush_1", FL);
      idle();
      step("br_release_flush_2", FL);
      step("br_release_flush_3", FL);
      step("br_release_done", NORM);

      // Timeout: stalled cycle s sees mem_timeout=1 from s=9 (8th cycle spent in MEM_WAIT)
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int s = 1; s <= 10; s++) begin
         #1;
         chkTo($sformatf("timeout_s%0d", s), (s >= 9) ? 1'b1 : 1'b0);
         chkOut($sformatf("timeout_frz_s%0d", s), FRZ);
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      #1;
      chkTo("timeout_sticky_ready", 1'b1);
      step("timeout_ready_outs", NORM);
      idle();
      #1;
      chkTo("timeout_sticky_idle", 1'b1);
      @(posedge clk); #1;

      // Reset mid-wait: immediate reset values, counter and flag cleared
      mem_req = 1'b1; mem_ready = 1'b0;
      step("pre_reset_wait_1", FRZ);
      step("pre_reset_wait_2", FRZ);
      rst_n = 1'b0;
      #1;
      chkOut("midwait_reset_outs", RST);
      chkTo("midwait_reset_timeout", 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int s = 1; s <= 9; s++) begin
         #1;
         chkTo($sformatf("post_reset_s%0d", s), (s >= 9) ? 1'b1 : 1'b0);
         @(posedge clk); #1;
      end
      idle();
      step("final_idle", NORM);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
